// File: rtl/pp_loop_monitor.sv
`default_nettype none
// ============================================================================
// Module      : pp_loop_monitor
// Description : Tracks the phase, iteration counts, in-flight depth and sticky
//               protocol errors of one pipelined HLS loop.
// Revision    : 1.0 - initial release
// ============================================================================
module pp_loop_monitor #(
    parameter int FSM_WIDTH    = 2,
    parameter int MAX_INFLIGHT = 8,
    parameter int CNT_WIDTH    = 16,
    localparam int IW          = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [FSM_WIDTH-1:0] cur_state,
    input  logic                 pre_states_valid,
    input  logic [FSM_WIDTH-1:0] pre_loop_state0,
    input  logic                 post_states_valid,
    input  logic [FSM_WIDTH-1:0] post_loop_state0,
    input  logic [FSM_WIDTH-1:0] loop_quit_state,
    input  logic [FSM_WIDTH-1:0] iter_start_state,
    input  logic                 iter_start_enable,
    input  logic                 iter_start_block,
    input  logic [FSM_WIDTH-1:0] iter_end_state,
    input  logic                 iter_end_enable,
    input  logic                 iter_end_block,
    input  logic                 quit_at_end,
    input  logic                 finish,
    output logic [2:0]           phase,
    output logic [IW-1:0]        inflight,
    output logic [CNT_WIDTH-1:0] iter_issued,
    output logic [CNT_WIDTH-1:0] iter_retired,
    output logic [CNT_WIDTH-1:0] loop_execs,
    output logic                 loop_done,
    output logic                 finished,
    output logic [3:0]           err
);

    localparam logic [IW-1:0] C_MAX = IW'(MAX_INFLIGHT);

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_PRE   = 3'd1,
        PH_RUN   = 3'd2,
        PH_DRAIN = 3'd3,
        PH_POST  = 3'd4
    } phase_t;

    phase_t          r_state;
    phase_t          w_state_nxt;
    logic            w_s;
    logic            w_e;
    logic            w_q;
    logic            w_ovf;
    logic            w_udf;
    logic            w_done;
    logic            w_early;
    logic            w_goto_done;
    logic [IW-1:0]   w_inflight_nxt;

    assign w_s   = (cur_state == iter_start_state) & iter_start_enable & ~iter_start_block;
    assign w_e   = (cur_state == iter_end_state) & iter_end_enable & ~iter_end_block;
    assign w_q   = (cur_state == loop_quit_state);
    assign w_ovf = w_s & ~w_e & (inflight == C_MAX);
    assign w_udf = w_e & ~w_s & (inflight == '0);

    // Saturating depth: overflow holds at MAX, underflow holds at zero.
    always_comb begin
        w_inflight_nxt = inflight;
        if (w_s & ~w_e & ~w_ovf) begin
            w_inflight_nxt = inflight + IW'(1);
        end else if (w_e & ~w_s & ~w_udf) begin
            w_inflight_nxt = inflight - IW'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_early     = 1'b0;
        w_goto_done = 1'b0;
        case (r_state)
            PH_IDLE: begin
                if (pre_states_valid && (cur_state == pre_loop_state0)) begin
                    w_state_nxt = PH_PRE;
                end else if (w_s) begin
                    w_state_nxt = PH_RUN;
                end
            end
            PH_PRE: begin
                if (w_s) begin
                    w_state_nxt = PH_RUN;
                end
            end
            PH_RUN: begin
                if (w_q) begin
                    w_early = quit_at_end & (w_inflight_nxt != '0);
                    if (w_inflight_nxt == '0) begin
                        w_goto_done = 1'b1;
                    end else begin
                        w_state_nxt = PH_DRAIN;
                    end
                end
            end
            PH_DRAIN: begin
                w_early = w_s;
                if (w_inflight_nxt == '0) begin
                    w_goto_done = 1'b1;
                end
            end
            PH_POST: begin
                if (cur_state == post_loop_state0) begin
                    w_state_nxt = PH_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = PH_IDLE;
        endcase
        // Loop completion is not a state: it resolves straight to POST or IDLE.
        if (w_goto_done) begin
            if (post_states_valid) begin
                w_state_nxt = PH_POST;
            end else begin
                w_state_nxt = PH_IDLE;
                w_done      = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= PH_IDLE;
            inflight     <= '0;
            iter_issued  <= '0;
            iter_retired <= '0;
            loop_execs   <= '0;
            loop_done    <= 1'b0;
            finished     <= 1'b0;
            err          <= '0;
        end else if (finished) begin
            loop_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            inflight     <= w_inflight_nxt;
            iter_issued  <= iter_issued + CNT_WIDTH'(w_s);
            iter_retired <= iter_retired + CNT_WIDTH'(w_e & ~w_udf);
            loop_execs   <= loop_execs + CNT_WIDTH'(w_done);
            loop_done    <= w_done;
            finished     <= finish;
            err          <= err | {finish & (r_state != PH_IDLE), w_early, w_udf, w_ovf};
        end
    end

    assign phase = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pp_loop_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_pp_loop_monitor
// Description : Directed, table-driven self-checking bench for pp_loop_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pp_loop_monitor;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] cur_state;
    logic       pre_states_valid;
    logic [1:0] pre_loop_state0;
    logic       post_states_valid;
    logic [1:0] post_loop_state0;
    logic [1:0] loop_quit_state;
    logic [1:0] iter_start_state;
    logic       iter_start_enable;
    logic       iter_start_block;
    logic [1:0] iter_end_state;
    logic       iter_end_enable;
    logic       iter_end_block;
    logic       quit_at_end;
    logic       finish;

    logic [2:0]  phase8,  phase2;
    logic [3:0]  infl8;
    logic [1:0]  infl2;
    logic [15:0] iss8, ret8, ex8, iss2, ret2, ex2;
    logic        done8, fin8, done2, fin2;
    logic [3:0]  err8, err2;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    pp_loop_monitor #(.FSM_WIDTH(2), .MAX_INFLIGHT(8), .CNT_WIDTH(16)) dut8 (
        .clock(clock), .reset(reset), .cur_state(cur_state),
        .pre_states_valid(pre_states_valid), .pre_loop_state0(pre_loop_state0),
        .post_states_valid(post_states_valid), .post_loop_state0(post_loop_state0),
        .loop_quit_state(loop_quit_state), .iter_start_state(iter_start_state),
        .iter_start_enable(iter_start_enable), .iter_start_block(iter_start_block),
        .iter_end_state(iter_end_state), .iter_end_enable(iter_end_enable),
        .iter_end_block(iter_end_block), .quit_at_end(quit_at_end), .finish(finish),
        .phase(phase8), .inflight(infl8), .iter_issued(iss8), .iter_retired(ret8),
        .loop_execs(ex8), .loop_done(done8), .finished(fin8), .err(err8)
    );

    pp_loop_monitor #(.FSM_WIDTH(2), .MAX_INFLIGHT(2), .CNT_WIDTH(16)) dut2 (
        .clock(clock), .reset(reset), .cur_state(cur_state),
        .pre_states_valid(pre_states_valid), .pre_loop_state0(pre_loop_state0),
        .post_states_valid(post_states_valid), .post_loop_state0(post_loop_state0),
        .loop_quit_state(loop_quit_state), .iter_start_state(iter_start_state),
        .iter_start_enable(iter_start_enable), .iter_start_block(iter_start_block),
        .iter_end_state(iter_end_state), .iter_end_enable(iter_end_enable),
        .iter_end_block(iter_end_block), .quit_at_end(quit_at_end), .finish(finish),
        .phase(phase2), .inflight(infl2), .iter_issued(iss2), .iter_retired(ret2),
        .loop_execs(ex2), .loop_done(done2), .finished(fin2), .err(err2)
    );

    // s/e code: 0 idle, 1 event, 2 enabled but blocked, 3 enabled with state mismatch
    typedef struct {
        logic [1:0] s, e;
        logic       q, pv, p, ov, o, qa, f;
        logic [2:0] ph;
        int         inf, iss, ret, ex;
        logic       d, fd;
        logic [3:0] er;
    } vec_t;

    localparam int NV = 28;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic [1:0] s, e, input logic q, pv, p, ov, o, qa, f,
                                input logic [2:0] ph, input int inf, iss, ret, ex,
                                input logic d, fd, input logic [3:0] er);
        vec_t v;
        v.s = s; v.e = e; v.q = q; v.pv = pv; v.p = p; v.ov = ov; v.o = o; v.qa = qa; v.f = f;
        v.ph = ph; v.inf = inf; v.iss = iss; v.ret = ret; v.ex = ex; v.d = d; v.fd = fd; v.er = er;
        return v;
    endfunction

    task automatic drive(input logic [1:0] s, e, input logic q, pv, p, ov, o, qa, f);
        cur_state         = 2'd1;
        iter_start_state  = (s == 2'd3) ? 2'd2 : 2'd1;
        iter_start_enable = (s != 2'd0);
        iter_start_block  = (s == 2'd2);
        iter_end_state    = (e == 2'd3) ? 2'd2 : 2'd1;
        iter_end_enable   = (e != 2'd0);
        iter_end_block    = (e == 2'd2);
        loop_quit_state   = q ? 2'd1 : 2'd2;
        pre_states_valid  = pv;
        pre_loop_state0   = p ? 2'd1 : 2'd2;
        post_states_valid = ov;
        post_loop_state0  = o ? 2'd1 : 2'd2;
        quit_at_end       = qa;
        finish            = f;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic [1:0] s, e, input logic q, qa);
        @(negedge clock);
        drive(s, e, q, 1'b0, 1'b0, 1'b0, 1'b0, qa, 1'b0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        //            s     e    q  pv p  ov o  qa f    ph inf iss ret ex d  fd err
        tbl[0]  = mk(2'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0,  2, 1, 1, 0, 0, 0, 0, 4'd0);
        tbl[1]  = mk(2'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0,  2, 2, 2, 0, 0, 0, 0, 4'd0);
        tbl[2]  = mk(2'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0,  2, 3, 3, 0, 0, 0, 0, 4'd0);
        tbl[3]  = mk(2'd1, 2'd1, 0, 0, 0, 0, 0, 0, 0,  2, 3, 4, 1, 0, 0, 0, 4'd0);
        tbl[4]  = mk(2'd0, 2'd1, 0, 0, 0, 0, 0, 0, 0,  2, 2, 4, 2, 0, 0, 0, 4'd0);
        tbl[5]  = mk(2'd0, 2'd1, 0, 0, 0, 0, 0, 0, 0,  2, 1, 4, 3, 0, 0, 0, 4'd0);
        tbl[6]  = mk(2'd0, 2'd1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 4, 4, 1, 1, 0, 4'd0);
        tbl[7]  = mk(2'd2, 2'd3, 0, 0, 0, 0, 0, 0, 0,  0, 0, 4, 4, 1, 0, 0, 4'd0);
        tbl[8]  = mk(2'd1, 2'd0, 0, 0, 0, 1, 0, 0, 0,  2, 1, 5, 4, 1, 0, 0, 4'd0);
        tbl[9]  = mk(2'd1, 2'd0, 0, 0, 0, 1, 0, 0, 0,  2, 2, 6, 4, 1, 0, 0, 4'd0);
        tbl[10] = mk(2'd0, 2'd0, 1, 0, 0, 1, 0, 0, 0,  3, 2, 6, 4, 1, 0, 0, 4'd0);
        tbl[11] = mk(2'd0, 2'd1, 0, 0, 0, 1, 0, 0, 0,  3, 1, 6, 5, 1, 0, 0, 4'd0);
        tbl[12] = mk(2'd0, 2'd1, 0, 0, 0, 1, 0, 0, 0,  4, 0, 6, 6, 1, 0, 0, 4'd0);
        tbl[13] = mk(2'd0, 2'd0, 0, 0, 0, 1, 0, 0, 0,  4, 0, 6, 6, 1, 0, 0, 4'd0);
        tbl[14] = mk(2'd0, 2'd0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 6, 6, 2, 1, 0, 4'd0);
        tbl[15] = mk(2'd2, 2'd2, 0, 0, 0, 0, 0, 0, 0,  0, 0, 6, 6, 2, 0, 0, 4'd0);
        tbl[16] = mk(2'd0, 2'd0, 0, 1, 1, 0, 0, 0, 0,  1, 0, 6, 6, 2, 0, 0, 4'd0);
        tbl[17] = mk(2'd0, 2'd0, 0, 1, 0, 0, 0, 0, 0,  1, 0, 6, 6, 2, 0, 0, 4'd0);
        tbl[18] = mk(2'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0,  2, 1, 7, 6, 2, 0, 0, 4'd0);
        tbl[19] = mk(2'd0, 2'd1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 7, 7, 3, 1, 0, 4'd0);
        tbl[20] = mk(2'd0, 2'd1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 7, 7, 3, 0, 0, 4'd2);
        tbl[21] = mk(2'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0,  2, 1, 8, 7, 3, 0, 0, 4'd2);
        tbl[22] = mk(2'd0, 2'd0, 1, 0, 0, 0, 0, 1, 0,  3, 1, 8, 7, 3, 0, 0, 4'd6);
        tbl[23] = mk(2'd0, 2'd1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 8, 8, 4, 1, 0, 4'd6);
        tbl[24] = mk(2'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0,  2, 1, 9, 8, 4, 0, 0, 4'd6);
        tbl[25] = mk(2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1,  2, 1, 9, 8, 4, 0, 1, 4'd14);
        tbl[26] = mk(2'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0,  2, 1, 9, 8, 4, 0, 1, 4'd14);
        tbl[27] = mk(2'd0, 2'd1, 1, 0, 0, 0, 0, 0, 0,  2, 1, 9, 8, 4, 0, 1, 4'd14);

        drive(2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("rst.phase", 32'(phase8), 0);
        chk("rst.inflight", 32'(infl8), 0);
        chk("rst.issued", 32'(iss8), 0);
        chk("rst.retired", 32'(ret8), 0);
        chk("rst.execs", 32'(ex8), 0);
        chk("rst.done", 32'(done8), 0);
        chk("rst.finished", 32'(fin8), 0);
        chk("rst.err", 32'(err8), 0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            drive(tbl[i].s, tbl[i].e, tbl[i].q, tbl[i].pv, tbl[i].p, tbl[i].ov, tbl[i].o,
                  tbl[i].qa, tbl[i].f);
            @(posedge clock);
            #1;
            chk($sformatf("v%0d.phase", i), 32'(phase8), 32'(tbl[i].ph));
            chk($sformatf("v%0d.inflight", i), 32'(infl8), tbl[i].inf);
            chk($sformatf("v%0d.issued", i), 32'(iss8), tbl[i].iss);
            chk($sformatf("v%0d.retired", i), 32'(ret8), tbl[i].ret);
            chk($sformatf("v%0d.execs", i), 32'(ex8), tbl[i].ex);
            chk($sformatf("v%0d.done", i), 32'(done8), 32'(tbl[i].d));
            chk($sformatf("v%0d.finished", i), 32'(fin8), 32'(tbl[i].fd));
            chk($sformatf("v%0d.err", i), 32'(err8), 32'(tbl[i].er));
        end

        // Asynchronous reset must override the frozen state immediately.
        @(negedge clock);
        drive(2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        chk("async.phase", 32'(phase8), 0);
        chk("async.finished", 32'(fin8), 0);
        chk("async.err", 32'(err8), 0);
        chk("async.issued", 32'(iss8), 0);
        @(negedge clock);
        reset = 1'b1;

        // Saturation on the depth-2 instance.
        step(2'd1, 2'd0, 0, 0);
        step(2'd1, 2'd0, 0, 0);
        chk("sat.inflight2_before", 32'(infl2), 2);
        chk("sat.err2_before", 32'(err2), 0);
        step(2'd1, 2'd0, 0, 0);
        chk("sat.inflight2", 32'(infl2), 2);
        chk("sat.issued2", 32'(iss2), 3);
        chk("sat.err2", 32'(err2), 1);
        chk("sat.inflight8", 32'(infl8), 3);
        chk("sat.err8", 32'(err8), 0);

        // Drain with an illegal issue, then reset mid-drain.
        step(2'd0, 2'd0, 1, 0);
        chk("drain.phase", 32'(phase8), 3);
        chk("drain.inflight", 32'(infl8), 3);
        step(2'd1, 2'd0, 0, 0);
        chk("drain_s.inflight", 32'(infl8), 4);
        chk("drain_s.issued", 32'(iss8), 4);
        chk("drain_s.err", 32'(err8), 4);
        step(2'd0, 2'd1, 0, 0);
        chk("drain_e.inflight", 32'(infl8), 3);
        chk("drain_e.phase", 32'(phase8), 3);
        chk("drain_e.retired", 32'(ret8), 1);

        @(negedge clock);
        drive(2'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("midrst.phase", 32'(phase8), 0);
        chk("midrst.inflight", 32'(infl8), 0);
        chk("midrst.issued", 32'(iss8), 0);
        chk("midrst.retired", 32'(ret8), 0);
        chk("midrst.execs", 32'(ex8), 0);
        chk("midrst.err", 32'(err8), 0);
        chk("midrst.err2", 32'(err2), 0);
        @(negedge clock);
        reset = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
